// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// Digit width, add-3 threshold/increment and the saturation digit live here so
// the digit adjuster and the controller agree on them.
package bin_to_bcd_seq_pkg;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_ADD    = 4'd3;
  localparam logic [3:0]  BCD_NINE   = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_adj.sv
// One BCD digit adjust step of double dabble: add 3 when the digit is >= 5.
// Purely combinational, zero latency, no flow control.
// Arithmetic wraps at 4 bits; wrapped values only occur on overflow and are discarded.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Conditional +3 so the following left shift carries correctly into the next digit
  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: done pulses in the cycle after edge k+BIN_W for a start accepted at edge k.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      overflow
);

  localparam int SCR_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   shreg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   scratch_shift;
  logic [SCR_W-1:0]   nines;
  logic               ovf;
  logic               ovf_shift;
  logic [CNT_W-1:0]   cnt;
  logic               last_shift;

  // Per-digit add-3 correction ahead of every shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[g*DIGIT_W +: DIGIT_W]),
      .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Next scratch value after the shift; the bit leaving the top digit marks overflow
  always_comb begin
    scratch_shift = {scratch_adj[SCR_W-2:0], shreg[BIN_W-1]};
    ovf_shift     = ovf | scratch_adj[SCR_W-1];
    last_shift    = (state == SHIFT) && (cnt == CNT_W'(1));
    nines         = {DIGITS{BCD_NINE}};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept start in IDLE, run BIN_W shifts, hold DONE for one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state: busy covers SHIFT and DONE, done is the DONE cycle
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: load on accepted start, shift each SHIFT cycle, publish saturated result on the last shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      scratch  <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            ovf     <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          scratch <= scratch_shift;
          ovf     <= ovf_shift;
          cnt     <= cnt - CNT_W'(1);
          if (last_shift) begin
            bcd_out  <= ovf_shift ? nines : scratch_shift;
            overflow <= ovf_shift;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
